counter_uart_reporter: RTL and testbench
========================================

COUNTER_UART_REPORTER -- requirements
Module: counter_uart_reporter

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer) clocks per bit.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-005 i_digit  input  14  current counter value to report (unsigned).
REQ-006 i_send  input  1  report request, sampled every clk; level or pulse.
REQ-007 o_tx  output  1  UART serial line, idle high, 8N1, LSB first.
REQ-008 o_busy  output  1  high while a report is in progress.
REQ-009 o_done  output  1  one-cycle pulse after last stop bit of a report.

Function
REQ-010 Report = ASCII decimal of i_digit, 4 chars (thousands, hundreds, tens, ones), leading zeros kept, optionally followed by CR (0x0D), LF (0x0A) per REQ-030.
REQ-011 Values above 9999 shall be clamped and reported as "9999".
REQ-012 i_digit shall be captured on the accepting clock edge; later changes to i_digit shall not affect the report in progress.
REQ-013 States: IDLE, START, DATA, STOP; character index 0..N-1 and bit index 0..7 as counters.
REQ-014 IDLE: o_tx=1, o_busy=0; i_send=1 accepts a request -> START on the next edge.
REQ-015 o_busy shall be 1 from the cycle after acceptance through the final stop-bit cycle, inclusive.
REQ-016 START: o_tx=0 for exactly BAUD_DIV clocks -> DATA.
REQ-017 DATA: o_tx = char bit[bit index], each for exactly BAUD_DIV clocks, bit 0 first; after bit 7 -> STOP.
REQ-018 STOP: o_tx=1 for exactly BAUD_DIV clocks; if more chars -> START (no idle gap), else -> IDLE with o_done=1 for one cycle.
REQ-019 Baud counter shall restart at 0 on acceptance; total report length exactly N*10*BAUD_DIV clocks.
REQ-020 i_send while o_busy=1 shall be ignored (not queued).
REQ-021 i_send held high continuously: a new report shall be accepted in the IDLE cycle following o_done, i.e. reports repeat back-to-back with one idle-high cycle between them.
REQ-022 o_tx shall be driven from a register (glitch-free).

Reset
REQ-023 reset=0 shall immediately, independent of clk, force: state IDLE, o_tx=1, o_busy=0, o_done=0, all counters and captured value 0.
REQ-024 Reset mid-report shall abort the frame; after release no remaining bits are sent and the block waits in IDLE for i_send.
REQ-025 First acceptance shall occur no earlier than the first rising edge with reset=1 and i_send=1.

Configuration
REQ-030 Macro REPORT_CRLF_EN: defined -> N=6 (4 digits + CR + LF); undefined -> N=4 (digits only). No other behaviour differs.

Verification (CLK_FREQ=1000, BAUD=100, BAUD_DIV=10)
REQ-040 REPORT_CRLF_EN defined, i_digit=1234, 1-cycle i_send -> o_tx decodes 0x31,0x32,0x33,0x34,0x0D,0x0A; o_busy high 600 clocks; o_done one pulse at end.
REQ-041 i_digit=0 -> "0000" (0x30 x4); i_digit=16383 -> "9999" (0x39 x4).
REQ-042 i_digit changed 1234->5678 on cycle 50 of a report, extra i_send pulses at cycles 50 and 300 -> still "1234", exactly one o_done, no second report.
REQ-043 reset asserted at cycle 137 of a report -> o_tx=1, o_busy=0 same cycle without clk edge; after release, o_tx stays 1 for 1000 clocks with i_send=0.
REQ-044 REPORT_CRLF_EN undefined, i_digit=42, i_send held high 900 clocks -> "0042" repeated, each report 400 clocks, one idle-high cycle between reports.
REQ-045 Each bit period measured at o_tx edges is exactly 10 clocks; start bit begins the cycle after acceptance.

Source files
------------

// File: rtl/counter_uart_reporter.sv
// Reports a 14-bit counter value as ASCII decimal over an 8N1 UART line.
// Define REPORT_CRLF_EN to append CR/LF to each report (6 characters instead of 4).
module counter_uart_reporter #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] i_digit,
    input  logic        i_send,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
`ifdef REPORT_CRLF_EN
    localparam int N_CHARS  = 6;
`else
    localparam int N_CHARS  = 4;
`endif
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       CHAR_LAST = 3'(N_CHARS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       char_idx;
    logic [2:0]       bit_idx;
    logic [6:0]       shift_q;
    logic [15:0]      digits_q;
    logic [7:0]       cur_char;
    logic [13:0]      clamped;
    logic [15:0]      bcd;
    logic             baud_last;

    // Values above 9999 cannot be shown in four digits, so they saturate.
    assign clamped   = (i_digit > 14'd9999) ? 14'd9999 : i_digit;
    assign bcd       = {4'(clamped / 14'd1000),
                        4'((clamped / 14'd100) % 14'd10),
                        4'((clamped / 14'd10) % 14'd10),
                        4'(clamped % 14'd10)};
    assign baud_last = (baud_cnt == BAUD_LAST);

    always_comb begin
        // NOTE: default first so every path assigns cur_char and no latch is inferred.
        cur_char = 8'h30;
        case (char_idx)
            3'd0:    cur_char = {4'h3, digits_q[15:12]};
            3'd1:    cur_char = {4'h3, digits_q[11:8]};
            3'd2:    cur_char = {4'h3, digits_q[7:4]};
            3'd3:    cur_char = {4'h3, digits_q[3:0]};
            3'd4:    cur_char = 8'h0D;
            3'd5:    cur_char = 8'h0A;
            default: cur_char = 8'h30;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            char_idx <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            // NOTE: the captured value is a handful of flops, not a memory, so it is cleared with everything else.
            digits_q <= '0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                    if (i_send) begin
                        digits_q <= bcd;
                        char_idx <= '0;
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                        o_tx     <= 1'b0;
                        o_busy   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
                    if (baud_last) begin
                        o_tx    <= cur_char[0];
                        shift_q <= cur_char[7:1];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
                    if (baud_last) begin
                        if (bit_idx == 3'd7) begin
                            o_tx  <= 1'b1;
                            state <= STOP;
                        end else begin
                            o_tx    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[6:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
                    if (baud_last) begin
                        if (char_idx == CHAR_LAST) begin
                            char_idx <= '0;
                            o_tx     <= 1'b1;
                            o_busy   <= 1'b0;
                            o_done   <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // Next character starts straight after the stop bit.
                            char_idx <= char_idx + 3'd1;
                            o_tx     <= 1'b0;
                            state    <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_uart_reporter.sv
// Self-checking bench for counter_uart_reporter at CLK_FREQ=1000, BAUD=100 (10 clocks per bit).
// Honours REPORT_CRLF_EN the same way the design does.
module tb_counter_uart_reporter;

    localparam int BIT = 10;
`ifdef REPORT_CRLF_EN
    localparam int N = 6;
`else
    localparam int N = 4;
`endif
    localparam int REP = N * 10 * BIT;
    localparam int WIN = 1200;

    typedef struct {
        logic [13:0] digit;
        logic [31:0] text;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] i_digit = '0;
    logic        i_send = 1'b0;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int failures = 0;

    logic       tx_log   [0:WIN-1];
    logic       busy_log [0:WIN-1];
    logic       done_log [0:WIN-1];
    logic [7:0] exp_chars[0:5];

    counter_uart_reporter #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clk(clk), .reset(reset), .i_digit(i_digit), .i_send(i_send),
        .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic set_expected(input logic [31:0] text);
        for (int k = 0; k < 4; k++) exp_chars[k] = text[31 - 8*k -: 8];
        exp_chars[4] = 8'h0D;
        exp_chars[5] = 8'h0A;
    endtask

    // Ideal line level at cycle i after acceptance (cycle 0 = first start-bit cycle).
    function automatic logic exp_tx_at(input int i);
        int k, pos;
        if (i >= REP) return 1'b1;
        k   = i / (10 * BIT);
        pos = (i % (10 * BIT)) / BIT;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return exp_chars[k][pos - 1];
    endfunction

    // One-cycle request, then log WIN cycles; optional extra i_send pulses and a digit change.
    task automatic capture(input logic [13:0] digit, input int poke_a, input int poke_b,
                           input logic [13:0] new_digit);
        @(negedge clk);
        i_digit = digit;
        i_send  = 1'b1;
        @(negedge clk);
        i_send = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            tx_log[i]   = o_tx;
            busy_log[i] = o_busy;
            done_log[i] = o_done;
            i_send = (i == poke_a || i == poke_b);
            if (i == poke_a) i_digit = new_digit;
            @(negedge clk);
        end
        i_send = 1'b0;
    endtask

    task automatic check_report(input string tag);
        logic [7:0] b;
        int tx_bad, busy_bad, busy_cnt, done_cnt;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 8; j++) b[j] = tx_log[k*10*BIT + BIT + j*BIT + BIT/2];
            check($sformatf("%s char%0d", tag, k), int'(b), int'(exp_chars[k]));
        end
        tx_bad = 0; busy_bad = 0; busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < WIN; i++) begin
            if (tx_log[i] !== exp_tx_at(i)) tx_bad++;
            if (busy_log[i] !== (i < REP)) busy_bad++;
            if (busy_log[i] === 1'b1) busy_cnt++;
            if (done_log[i] === 1'b1) done_cnt++;
        end
        check({tag, " tx waveform errors"}, tx_bad, 0);
        check({tag, " busy cycles"}, busy_cnt, REP);
        check({tag, " busy waveform errors"}, busy_bad, 0);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " done position"}, int'(done_log[REP]), 1);
    endtask

    initial begin
        vec_t vecs[8];
        int   bad, exp_done, done_cnt;

        vecs[0] = '{14'd1234,  "1234"};
        vecs[1] = '{14'd0,     "0000"};
        vecs[2] = '{14'd16383, "9999"};
        vecs[3] = '{14'd9999,  "9999"};
        vecs[4] = '{14'd10000, "9999"};
        vecs[5] = '{14'd42,    "0042"};
        vecs[6] = '{14'd7,     "0007"};
        vecs[7] = '{14'd905,   "0905"};

        // Requests during reset must not be accepted.
        i_send  = 1'b1;
        i_digit = 14'd1234;
        repeat (3) @(negedge clk);
        check("reset tx", int'(o_tx), 1);
        check("reset busy", int'(o_busy), 0);
        check("reset done", int'(o_done), 0);
        i_send = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        check("idle after reset busy", int'(o_busy), 0);
        check("idle after reset tx", int'(o_tx), 1);

        for (int v = 0; v < 8; v++) begin
            set_expected(vecs[v].text);
            capture(vecs[v].digit, -1, -1, 14'd0);
            check_report($sformatf("vec%0d(%0d)", v, vecs[v].digit));
        end

        // Input change and extra requests during a report are ignored.
        set_expected("1234");
        capture(14'd1234, 50, 300, 14'd5678);
        check_report("ignore-during-busy");

        // Asynchronous reset in the middle of a report.
        @(negedge clk);
        i_digit = 14'd1234;
        i_send  = 1'b1;
        @(negedge clk);
        i_send = 1'b0;
        repeat (137) @(negedge clk);
        check("pre-reset tx low", int'(o_tx), 0);
        check("pre-reset busy", int'(o_busy), 1);
        #2 reset = 1'b0;
        #1;
        check("async reset tx", int'(o_tx), 1);
        check("async reset busy", int'(o_busy), 0);
        check("async reset done", int'(o_done), 0);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
        end
        check("post-reset quiet cycles", bad, 0);

        // i_send held high: back-to-back reports with one idle cycle between them.
        set_expected("0042");
        @(negedge clk);
        i_digit = 14'd42;
        i_send  = 1'b1;
        @(negedge clk);
        bad = 0; exp_done = 0; done_cnt = 0;
        for (int i = 0; i < 900; i++) begin
            int r;
            r = i % (REP + 1);
            if (o_tx !== ((r < REP) ? exp_tx_at(r) : 1'b1)) bad++;
            if (o_busy !== (r < REP)) bad++;
            if (o_done !== (r == REP)) bad++;
            if (r == REP) exp_done++;
            if (o_done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("held-send waveform errors", bad, 0);
        check("held-send done pulses", done_cnt, exp_done);
        i_send = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
